// File: rtl/dpram_pkg.sv
// Shared defaults and helpers for the byte-enabled dual-port RAM family.
package dpram_pkg;

    localparam int DPRAM_WIDTHAD   = 14;
    localparam int DPRAM_WIDTH     = 16;
    localparam int DPRAM_BYTE_SIZE = 8;
    localparam int DPRAM_NUMWORDS  = 16384;

    // Upper bound on data width the mask helper can expand.
    localparam int DPRAM_MAX_WIDTH = 64;

    // Expand a byte-enable vector into a bit mask: bit i of the result
    // is set when the lane containing bit i is enabled.
    function automatic logic [DPRAM_MAX_WIDTH-1:0] lane_mask(
        input logic [DPRAM_MAX_WIDTH-1:0] be,
        input int                         byte_size
    );
        logic [DPRAM_MAX_WIDTH-1:0] m;
        logic [5:0]                 lane;
        m = '0;
        for (int i = 0; i < DPRAM_MAX_WIDTH; i++) begin
            lane = 6'(i / byte_size);
            m[6'(i)] = be[lane];
        end
        return m;
    endfunction

endpackage

// File: rtl/dpram_be_lane.sv
// One byte-lane column of the RAM: write port with its own enable and a
// registered read port. Shaped so each column maps onto one block RAM.
module dpram_be_lane #(
    parameter int WIDTHAD   = 14,
    parameter int NUMWORDS  = 16384,
    parameter int BYTE_SIZE = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 we_i,
    input  logic [WIDTHAD-1:0]   waddr_i,
    input  logic [BYTE_SIZE-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [WIDTHAD-1:0]   raddr_i,
    output logic [BYTE_SIZE-1:0] rdata_o
);

    // Contents start at zero through the declaration initialiser, which
    // FPGA tools turn into the block RAM init image.
    logic [BYTE_SIZE-1:0] mem_q [NUMWORDS] = '{default: '0};
    logic [BYTE_SIZE-1:0] rdata_q;

    // Write port: enable already qualified by reset, range and byte enable.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: samples the pre-write contents, giving old-data collisions.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dpram_be.sv
// Simple dual-port RAM, write port A with byte enables, read port B.
// Define DPRAM_BE_OUTREG_EN to add a second output register (latency 2).
module dpram_be
    import dpram_pkg::*;
#(
    parameter int WIDTHAD       = DPRAM_WIDTHAD,
    parameter int NUMWORDS      = DPRAM_NUMWORDS,
    parameter int WIDTH         = DPRAM_WIDTH,
    parameter int BYTE_SIZE     = DPRAM_BYTE_SIZE,
    parameter int WIDTH_BYTEENA = WIDTH / BYTE_SIZE
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTHAD-1:0]       address_a,
    input  logic [WIDTH-1:0]         data_a,
    input  logic [WIDTH_BYTEENA-1:0] byteena_a,
    input  logic                     wren_a,
    input  logic [WIDTHAD-1:0]       address_b,
    input  logic                     rden_b,
    output logic [WIDTH-1:0]         q_b
);

    if (WIDTH % BYTE_SIZE != 0) begin : g_err_width
        $error("dpram_be: WIDTH must be a multiple of BYTE_SIZE");
    end
    if (NUMWORDS > 2 ** WIDTHAD) begin : g_err_depth
        $error("dpram_be: NUMWORDS exceeds address space");
    end
    if (WIDTH > DPRAM_MAX_WIDTH) begin : g_err_max
        $error("dpram_be: WIDTH exceeds lane_mask capacity");
    end

    localparam logic [WIDTHAD:0] NUMWORDS_W = (WIDTHAD + 1)'(NUMWORDS);

    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_ok;
    logic             rd_ok;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] q1;
    logic             oor_q;

    assign wr_in_range = {1'b0, address_a} < NUMWORDS_W;
    assign rd_in_range = {1'b0, address_b} < NUMWORDS_W;
    assign wr_ok       = wren_a && !reset && wr_in_range;
    assign rd_ok       = rden_b && !reset && rd_in_range;
    assign wmask       = WIDTH'(lane_mask(DPRAM_MAX_WIDTH'(byteena_a), BYTE_SIZE));

    for (genvar gi = 0; gi < WIDTH_BYTEENA; gi++) begin : g_lane
        logic lane_we;
        assign lane_we = wr_ok && (&wmask[gi*BYTE_SIZE +: BYTE_SIZE]);

        dpram_be_lane #(
            .WIDTHAD   (WIDTHAD),
            .NUMWORDS  (NUMWORDS),
            .BYTE_SIZE (BYTE_SIZE)
        ) u_lane (
            .clock   (clock),
            .reset   (reset),
            .we_i    (lane_we),
            .waddr_i (address_a),
            .wdata_i (data_a[gi*BYTE_SIZE +: BYTE_SIZE]),
            .re_i    (rd_ok),
            .raddr_i (address_b),
            .rdata_o (rd_word[gi*BYTE_SIZE +: BYTE_SIZE])
        );
    end

    // Remembers whether the sampled read address fell outside the array;
    // reset returns it to address 0, which is always in range.
    always_ff @(posedge clock) begin
        if (reset) begin
            oor_q <= 1'b0;
        end else if (rden_b) begin
            oor_q <= !rd_in_range;
        end
    end

    assign q1 = oor_q ? '0 : rd_word;

`ifdef DPRAM_BE_OUTREG_EN
    logic [WIDTH-1:0] q2_q;

    // Extra output stage, reloaded every cycle and cleared with stage one.
    always_ff @(posedge clock) begin
        if (reset) begin
            q2_q <= '0;
        end else begin
            q2_q <= q1;
        end
    end

    assign q_b = q2_q;
`else
    assign q_b = q1;
`endif

endmodule

// File: tb/tb_dpram_be.sv
// Directed bench for dpram_be; honours DPRAM_BE_OUTREG_EN for latency.
module tb_dpram_be;

`ifdef DPRAM_BE_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] address_a = '0;
    logic [15:0] data_a = '0;
    logic [1:0]  byteena_a = '0;
    logic        wren_a = 1'b0;
    logic [13:0] address_b = '0;
    logic        rden_b = 1'b0;
    logic [15:0] q_b;

    int n_checks = 0;
    int n_errors = 0;

    dpram_be dut (
        .clock     (clock),
        .reset     (reset),
        .address_a (address_a),
        .data_a    (data_a),
        .byteena_a (byteena_a),
        .wren_a    (wren_a),
        .address_b (address_b),
        .rden_b    (rden_b),
        .q_b       (q_b)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: q_b=%h", tag, got);
        end
    endtask

    task automatic wr(input logic [13:0] a, input logic [15:0] d, input logic [1:0] be);
        address_a = a;
        data_a    = d;
        byteena_a = be;
        wren_a    = 1'b1;
        tick();
        wren_a    = 1'b0;
    endtask

    task automatic rd(input logic [13:0] a);
        address_b = a;
        rden_b    = 1'b1;
        tick();
        rden_b    = 1'b0;
        repeat (LAT - 1) tick();
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        check("reset_q", q_b, 16'h0000);
        reset = 1'b0;

        rd(14'h3FFF);
        check("powerup_3fff", q_b, 16'h0000);

        // Full write, then read with explicit latency observation.
        wr(14'h0010, 16'hA5C3, 2'b11);
        address_b = 14'h0010;
        rden_b    = 1'b1;
        tick();
        rden_b    = 1'b0;
`ifdef DPRAM_BE_OUTREG_EN
        check("lat2_not_yet", q_b, 16'h0000);
        tick();
`endif
        check("full_rw", q_b, 16'hA5C3);

        // Byte lanes.
        wr(14'd5, 16'h1234, 2'b11);
        wr(14'd5, 16'hABCD, 2'b01);
        rd(14'd5);
        check("lane_lo", q_b, 16'h12CD);
        wr(14'd5, 16'hEF00, 2'b10);
        rd(14'd5);
        check("lane_hi", q_b, 16'hEFCD);
        wr(14'd5, 16'h0000, 2'b00);
        rd(14'd5);
        check("be_zero", q_b, 16'hEFCD);

        // Collision returns old data, next read sees new.
        wr(14'd7, 16'h1111, 2'b11);
        address_a = 14'd7;
        data_a    = 16'h2222;
        byteena_a = 2'b11;
        wren_a    = 1'b1;
        address_b = 14'd7;
        rden_b    = 1'b1;
        tick();
        wren_a    = 1'b0;
        rden_b    = 1'b0;
        repeat (LAT - 1) tick();
        check("collide_old", q_b, 16'h1111);
        rd(14'd7);
        check("collide_new", q_b, 16'h2222);

        // Streaming reads on consecutive cycles.
        wr(14'd0, 16'h0001, 2'b11);
        wr(14'd1, 16'h0002, 2'b11);
        wr(14'd2, 16'h0003, 2'b11);
        for (int k = 0; k < 3 + LAT - 1; k++) begin
            address_b = 14'(k);
            rden_b    = (k < 3);
            tick();
            if (k >= LAT - 1) begin
                check($sformatf("stream_%0d", k - LAT + 1), q_b, 16'(k - LAT + 2));
            end
        end
        rden_b = 1'b0;

        // Reset clears output, blocks a write, keeps contents.
        rd(14'h0010);
        check("pre_reset", q_b, 16'hA5C3);
        reset     = 1'b1;
        address_a = 14'h0010;
        data_a    = 16'hFFFF;
        byteena_a = 2'b11;
        wren_a    = 1'b1;
        tick();
        reset  = 1'b0;
        wren_a = 1'b0;
        check("reset_clears", q_b, 16'h0000);
        rd(14'h0010);
        check("post_reset", q_b, 16'hA5C3);

        // Read enable low holds the output while the address moves.
        rden_b    = 1'b0;
        address_b = 14'd5;
        tick();
        tick();
        tick();
        check("rden_hold", q_b, 16'hA5C3);
        rd(14'd5);
        check("rden_resume", q_b, 16'hEFCD);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
